// File: rtl/transmitter_mensah_if.sv
// Handshake and serial-line bundle for transmitter_mensah.
// The bench drives through the master modport and the transmitter uses the slave modport.
interface transmitter_mensah_if #(
  parameter int DATA_BITS = 8
);
  logic                 enabled;
  logic                 s_tick;
  logic                 in_valid;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_ready;
  logic                 out;
  logic                 busy;
  logic                 done;

  modport master (
    output enabled,
    output s_tick,
    output in_valid,
    output in_data,
    input  in_ready,
    input  out,
    input  busy,
    input  done
  );

  modport slave (
    input  enabled,
    input  s_tick,
    input  in_valid,
    input  in_data,
    output in_ready,
    output out,
    output busy,
    output done
  );
endinterface

// File: rtl/transmitter_mensah.sv
// Oversampled serial transmitter with a one-word holding buffer so that frames can run back to back.
// Defining TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module transmitter_mensah #(
  parameter int OVERSAMPLE_RATE = 16,
  parameter int DATA_BITS       = 8
) (
  input  logic                  clk,
  input  logic                  rstN,
  transmitter_mensah_if.slave   bus
);
  localparam int             TW        = (OVERSAMPLE_RATE > 1) ? $clog2(OVERSAMPLE_RATE) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(OVERSAMPLE_RATE - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 out_q, out_d;
  logic                 done_q, done_d;
`ifdef TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic                 accept_s;
  logic                 bit_end_s;
  logic                 load_s;
  logic [DATA_BITS-1:0] load_word_s;

  assign bus.in_ready = bus.enabled && !hold_full_q && !rstN;
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign bit_end_s    = bus.s_tick && (tick_q == TICK_LAST);

  assign bus.out  = out_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

  // Next-state logic: bit timing, frame sequencing and holding-buffer fill/drain.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;
    load_s      = 1'b0;
    load_word_s = hold_q;
`ifdef TX_PARITY_EN
    par_d       = par_q;
`endif

    if (state_q != IDLE && bus.s_tick) begin
      tick_d = bit_end_s ? '0 : tick_q + TW'(1);
    end else begin
      tick_d = tick_q;
    end

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          load_s      = 1'b1;
          load_word_s = bus.in_data;
          state_d     = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
`ifdef TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          done_d = 1'b1;
          // A buffered word starts its frame on this same edge, with no idle gap.
          if (hold_full_q) begin
            load_s      = 1'b1;
            load_word_s = hold_q;
            hold_full_d = 1'b0;
            state_d     = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Applied after the drain above so a same-clock accept refills the buffer.
    if (accept_s && state_q != IDLE) begin
      hold_d      = bus.in_data;
      hold_full_d = 1'b1;
    end else begin
      hold_d = hold_d;
    end

    if (load_s) begin
      shift_d = load_word_s;
      tick_d  = '0;
      bit_d   = 3'd0;
`ifdef TX_PARITY_EN
      par_d   = ^load_word_s;
`endif
    end else begin
      shift_d = shift_d;
    end
  end

  // Line level for the state being entered, so out changes on the same edge as the state.
  always_comb begin
    out_d = 1'b1;
    case (state_d)
      START:   out_d = 1'b0;
      DATA:    out_d = shift_d[0];
`ifdef TX_PARITY_EN
      PARITY:  out_d = par_d;
`endif
      default: out_d = 1'b1;
    endcase
  end

  // State and datapath registers; rstN is a synchronous active-high clear.
  always_ff @(posedge clk) begin
    if (rstN) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= 3'd0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      out_q       <= 1'b1;
      done_q      <= 1'b0;
`ifdef TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      out_q       <= out_d;
      done_q      <= done_d;
`ifdef TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_transmitter_mensah.sv
// Directed bench for transmitter_mensah: reset, single frames, back-to-back frames,
// mid-frame reset, enable gating and a slow tick rate; parity frames when TX_PARITY_EN is set.
module tb_transmitter_mensah;
`ifdef TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clk;
  logic rstN;
  int   checks;
  int   errors;
  int   div;
  int   div_cnt;

  transmitter_mensah_if #(.DATA_BITS(8)) bus ();

  transmitter_mensah #(.OVERSAMPLE_RATE(16), .DATA_BITS(8)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected line level for frame bit idx: start 0, data LSB first, optional parity, stop 1.
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef TX_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks follow the call.
  task automatic cyc();
    @(posedge clk);
    #1;
    div_cnt = (div_cnt + 1) % div;
    bus.s_tick = (div_cnt == 0);
  endtask

  // Tick every d clocks, with a tick on the very next edge.
  task automatic set_div(input int d);
    div        = d;
    div_cnt    = 0;
    bus.s_tick = 1'b1;
  endtask

  task automatic walk(input string tag, input logic [7:0] d, input int per, input int first);
    for (int k = first; k < NBITS * per; k++) begin
      chk({tag, "_out"}, 32'(bus.out), 32'(frame_bit(d, k / per)));
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      cyc();
    end
  endtask

  task automatic frame_end(input string tag);
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, "_out_end"}, 32'(bus.out), 32'd1);
    cyc();
    chk({tag, "_done_clear"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    div          = 1;
    div_cnt      = 0;
    rstN         = 1'b1;
    bus.enabled  = 1'b1;
    bus.s_tick   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state.
    cyc();
    cyc();
    chk("rst_out", 32'(bus.out), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    rstN = 1'b0;
    cyc();
    chk("idle_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_out", 32'(bus.out), 32'd1);

    // Single frame 0xA5, tick every clock.
    set_div(1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    cyc();
    bus.in_valid = 1'b0;
    walk("a5", 8'hA5, 16, 0);
    frame_end("a5");

    // Back-to-back 0x00 then 0xFF through the holding buffer.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    cyc();
    chk("b2b_start_out", 32'(bus.out), 32'd0);
    chk("b2b_ready_empty", 32'(bus.in_ready), 32'd1);
    bus.in_data = 8'hFF;
    cyc();
    bus.in_valid = 1'b0;
    chk("b2b_ready_full", 32'(bus.in_ready), 32'd0);
    walk("b2b_00", 8'h00, 16, 1);
    chk("b2b_mid_done", 32'(bus.done), 32'd1);
    chk("b2b_mid_busy", 32'(bus.busy), 32'd1);
    chk("b2b_mid_out", 32'(bus.out), 32'd0);
    chk("b2b_mid_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    walk("b2b_ff", 8'hFF, 16, 1);
    frame_end("b2b");

    // Reset during data bit 4 with a word buffered.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    cyc();
    bus.in_data = 8'h81;
    cyc();
    bus.in_valid = 1'b0;
    for (int k = 2; k < 85; k++) cyc();
    chk("mid_bit4_out", 32'(bus.out), 32'd1);
    chk("mid_bit4_busy", 32'(bus.busy), 32'd1);
    rstN = 1'b1;
    cyc();
    chk("mid_rst_out", 32'(bus.out), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    rstN = 1'b0;
    for (int k = 0; k < 200; k++) begin
      cyc();
      chk("post_rst_out", 32'(bus.out), 32'd1);
      chk("post_rst_busy", 32'(bus.busy), 32'd0);
      chk("post_rst_done", 32'(bus.done), 32'd0);
    end

    // Enable low blocks acceptance in IDLE.
    bus.enabled  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    #1;
    chk("dis_ready", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 20; k++) cyc();
    chk("dis_out", 32'(bus.out), 32'd1);
    chk("dis_busy", 32'(bus.busy), 32'd0);

    // Enable for one accept, then drop it: the frame still completes.
    bus.enabled = 1'b1;
    cyc();
    bus.enabled  = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("dis_mid_ready", 32'(bus.in_ready), 32'd0);
    walk("en_drop", 8'h55, 16, 0);
    frame_end("en_drop");
    bus.enabled = 1'b1;

    // Tick every third clock: each bit lasts 48 clocks.
    set_div(3);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    cyc();
    bus.in_valid = 1'b0;
    walk("slow", 8'h5A, 48, 0);
    frame_end("slow");

`ifdef TX_PARITY_EN
    // Parity frames: 0x07 carries parity 1, 0x03 carries parity 0.
    set_div(1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h07;
    cyc();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 9 * 16 + 8; k++) cyc();
    chk("par07_bit", 32'(bus.out), 32'd1);
    for (int k = 9 * 16 + 8; k < 11 * 16; k++) cyc();
    frame_end("par07");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h03;
    cyc();
    bus.in_valid = 1'b0;
    walk("par03", 8'h03, 16, 0);
    frame_end("par03");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/transmitter_mensah.md
TRANSMITTER_MENSAH -- requirements
Module: transmitter_mensah

Interface
REQ-001 SHALL have parameter OVERSAMPLE_RATE, default 16 (from definitions_pkg), s_tick pulses per bit period.
REQ-002 SHALL have parameter DATA_BITS, default 8, payload bits per frame.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rstN  input  1  reset; synchronous and active-high despite the name.
REQ-005 SHALL have port enabled  input  1  permits acceptance of new words.
REQ-006 SHALL have port s_tick  input  1  oversample tick, one-clk pulse.
REQ-007 SHALL have port in_valid  input  1  in_data holds a word to send.
REQ-008 SHALL have port in_data  input  8  parallel word to send.
REQ-009 SHALL have port in_ready  output  1  word accepted on any clk where in_valid && in_ready.
REQ-010 SHALL have port out  output  1  registered serial tx line, idle high.
REQ-011 SHALL have port busy  output  1  frame in progress.
REQ-012 SHALL have port done  output  1  one-clk pulse at end of each frame's stop bit.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-014 Each bit SHALL last exactly OVERSAMPLE_RATE s_ticks: the tick counter resets to 0 on bit entry, increments on s_tick, and the bit ends on the s_tick where counter == OVERSAMPLE_RATE-1.
REQ-015 out SHALL be 1 in IDLE and STOP, 0 in START, shift_reg[0] in DATA; data SHALL go LSB first, shifting right once per completed data bit.
REQ-016 DATA SHALL send exactly DATA_BITS bits (3-bit counter), then move to PARITY (if compiled) or STOP.
REQ-017 The block SHALL hold a one-entry holding buffer; in_ready = enabled && !buffer_full.
REQ-018 A word accepted in IDLE with the buffer empty SHALL load the shift register directly; state = START and out = 0 from the next clk.
REQ-019 A word accepted while busy SHALL go to the buffer; accept and drain in the same clk SHALL be legal and lose no data.
REQ-020 On stop-bit end, done SHALL pulse for one clk. With the buffer full, the FSM SHALL enter START on that same edge (no idle gap), loading the shift register and emptying the buffer; otherwise it SHALL enter IDLE.
REQ-021 busy SHALL be 1 in START/DATA/PARITY/STOP and 0 in IDLE; it SHALL stay 1 across back-to-back frames.
REQ-022 enabled low SHALL block acceptance only: an in-flight frame and a buffered word SHALL still transmit.
REQ-023 Between s_ticks, state and out SHALL hold; s_tick gaps of any length SHALL be tolerated.

Reset
REQ-024 On rstN high at a clk edge: state IDLE, out 1, busy 0, done 0, in_ready 0 while rstN is high, buffer empty, counters 0, shift register 0.
REQ-025 Reset mid-frame SHALL abort the frame; out SHALL be 1 from the next clk and any buffered word SHALL be discarded.

Configuration
REQ-026 Macro TX_PARITY_EN defined: a PARITY state of one bit period SHALL follow DATA, driving out = XOR of all data bits (even parity). Frame = 11 bit periods.
REQ-027 Macro TX_PARITY_EN undefined: no PARITY state or logic; DATA goes straight to STOP. Frame = 10 bit periods.

Verification
REQ-028 s_tick every clk, send 0xA5 in IDLE: out = 0,1,0,1,0,0,1,0,1,1, each 16 clks; done pulses once, 160 clks after START entry; busy then 0.
REQ-029 0x00 then 0xFF presented back to back: the second is buffered, and its start bit follows the first frame's stop bit with zero idle clks; busy stays 1 throughout; two done pulses.
REQ-030 TX_PARITY_EN, send 0x07: parity bit = 1; send 0x03: parity bit = 0; done after 176 ticks.
REQ-031 rstN asserted during DATA bit 4 with a word buffered: out = 1, busy = 0 next clk; no done; the buffered word is never sent.
REQ-032 enabled = 0 with in_valid = 1 in IDLE: in_ready = 0, out stays 1; enabled dropped mid-frame: the frame completes normally.
REQ-033 s_tick every 3rd clk, send 0x5A: each bit = 48 clks and the bit order is correct.
